// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and the
// start/done handshake with the multi-cycle EX unit, plus a saturating stall counter.
module hazard_control_unit #(
  parameter int REG_W      = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             id_ex_memread,
  input  logic             ex_mc_op,
  input  logic             mc_done,
  input  logic             branch_taken,
  output logic             mc_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MC_WAIT, ERR} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          lu;

  assign lu = id_ex_memread && (id_ex_rt != '0) &&
              ((id_ex_rt == if_id_rs) || (id_uses_rt && (id_ex_rt == if_id_rt)));

  always_comb begin
    mc_start      = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mc_op) begin
            mc_start      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MC_WAIT, ERR: begin
          // In MC_WAIT a done pulse releases the pipeline in the same cycle.
          if (state == ERR || !mc_done) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      timer     <= '0;
      stall_cnt <= '0;
      mc_err    <= 1'b0;
    end else begin
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        RUN: begin
          if (!branch_taken && ex_mc_op) begin
            state <= MC_WAIT;
            timer <= '0;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state <= RUN;
          end else if (timer == TIMER_LAST) begin
            state  <= ERR;
            mc_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ERR: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: table of single-cycle RUN vectors plus
// hand sequences for the multi-cycle handshake, timeout, saturation and reset.
module tb_hazard_control_unit;

  // {mc_start, pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, id_ex_flush}
  localparam logic [7:0] NORMAL = 8'b0111_0000;
  localparam logic [7:0] STALL  = 8'b0001_1000;
  localparam logic [7:0] BRANCH = 8'b0111_0011;
  localparam logic [7:0] START  = 8'b1000_0100;
  localparam logic [7:0] FREEZE = 8'b0000_0100;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic id_uses_rt, id_ex_memread, ex_mc_op, mc_done, branch_taken;
  logic mc_start, pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic if_id_flush, id_ex_flush, mc_err;
  logic [15:0] stall_cnt;
  logic mc_start4, pc_write4, if_id_write4, id_ex_write4, id_ex_bubble4, ex_mem_bubble4;
  logic if_id_flush4, id_ex_flush4, mc_err4;
  logic [3:0] stall_cnt4;
  logic [7:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign outs = {mc_start, pc_write, if_id_write, id_ex_write,
                 id_ex_bubble, ex_mem_bubble, if_id_flush, id_ex_flush};

  hazard_control_unit #(.REG_W(5), .MC_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_uses_rt(id_uses_rt), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .branch_taken(branch_taken),
    .mc_start(mc_start), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mc_err(mc_err),
    .stall_cnt(stall_cnt)
  );

  hazard_control_unit #(.REG_W(5), .MC_TIMEOUT(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_uses_rt(id_uses_rt), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .branch_taken(branch_taken),
    .mc_start(mc_start4), .pc_write(pc_write4), .if_id_write(if_id_write4),
    .id_ex_write(id_ex_write4), .id_ex_bubble(id_ex_bubble4), .ex_mem_bubble(ex_mem_bubble4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .mc_err(mc_err4),
    .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] ex_rt;
    logic       memread;
    logic       mc_op;
    logic       done;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Entered at a negedge: drive the handshake inputs, check outputs, advance one cycle.
  task automatic cyc(input logic op, input logic done, input logic br,
                     input logic [7:0] exp, input string nm);
    ex_mc_op = op;
    mc_done = done;
    branch_taken = br;
    #1;
    check(nm, {24'd0, outs}, {24'd0, exp});
    @(negedge clk);
  endtask

  task automatic clear_lu();
    if_id_rs = 5'd0;
    if_id_rt = 5'd0;
    id_uses_rt = 1'b0;
    id_ex_rt = 5'd0;
    id_ex_memread = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("outputs_in_reset", {24'd0, outs}, {24'd0, NORMAL});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[1]  = '{5'd5,  5'd0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, NORMAL};
    vecs[2]  = '{5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
    vecs[3]  = '{5'd3,  5'd5, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
    vecs[4]  = '{5'd3,  5'd5, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[5]  = '{5'd6,  5'd8, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
    vecs[6]  = '{5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1, BRANCH};
    vecs[7]  = '{5'd1,  5'd2, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, BRANCH};
    vecs[8]  = '{5'd4,  5'd4, 1'b1, 5'd4,  1'b1, 1'b0, 1'b1, 1'b0, STALL};
    vecs[9]  = '{5'd31, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[10] = '{5'd12, 5'd0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, NORMAL};

    rst = 1'b1;
    clear_lu();
    ex_mc_op = 1'b0;
    mc_done = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {24'd0, outs}, {24'd0, NORMAL});
    rst = 1'b0;
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("reset_mc_err", {31'd0, mc_err}, 32'd0);

    // RUN-state single-cycle vectors: 4 stalling entries.
    for (int i = 0; i < 11; i++) begin
      if_id_rs = vecs[i].rs;
      if_id_rt = vecs[i].rt;
      id_uses_rt = vecs[i].uses_rt;
      id_ex_rt = vecs[i].ex_rt;
      id_ex_memread = vecs[i].memread;
      cyc(vecs[i].mc_op, vecs[i].done, vecs[i].br, vecs[i].exp, $sformatf("vec%0d", i));
    end
    clear_lu();
    check("table_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    check("table_stall_cnt4", {28'd0, stall_cnt4}, 32'd4);

    // Multi-cycle op, done after 4 wait cycles; lu and branch ignored while waiting.
    if_id_rs = 5'd5;
    id_ex_rt = 5'd5;
    id_ex_memread = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, START, "mc_start");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, (i == 2), FREEZE, $sformatf("mc_freeze%0d", i));
    cyc(1'b1, 1'b1, 1'b0, NORMAL, "mc_release");
    clear_lu();
    cyc(1'b0, 1'b0, 1'b0, NORMAL, "after_release");
    check("mc_stall_cnt", {16'd0, stall_cnt}, 32'd9);
    check("mc_err_clear", {31'd0, mc_err}, 32'd0);

    // Timeout into ERR after 64 wait cycles, then late done ignored.
    do_reset();
    check("rst2_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, START, "to_start");
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("mc_err_before_timeout", {31'd0, mc_err}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, FREEZE, "to_freeze");
    end
    check("mc_err_set", {31'd0, mc_err}, 32'd1);
    check("mc_err4_set", {31'd0, mc_err4}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, FREEZE, "err_done_ignored");
    cyc(1'b0, 1'b0, 1'b1, FREEZE, "err_branch_ignored");
    check("err_sticky", {31'd0, mc_err}, 32'd1);
    check("err_stall_cnt", {16'd0, stall_cnt}, 32'd67);
    check("sat_stall_cnt4", {28'd0, stall_cnt4}, 32'd15);
    do_reset();
    check("rst3_mc_err", {31'd0, mc_err}, 32'd0);
    check("rst3_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst3_stall_cnt4", {28'd0, stall_cnt4}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, NORMAL, "run_after_err");

    // Reset in MC_WAIT with the op still present re-issues mc_start.
    cyc(1'b1, 1'b0, 1'b0, START, "t6_start");
    cyc(1'b1, 1'b0, 1'b0, FREEZE, "t6_freeze0");
    cyc(1'b1, 1'b0, 1'b0, FREEZE, "t6_freeze1");
    ex_mc_op = 1'b1;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, START, "t6_restart");
    cyc(1'b1, 1'b0, 1'b0, FREEZE, "t6_freeze2");
    cyc(1'b1, 1'b1, 1'b0, NORMAL, "t6_release");
    check("t6_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, NORMAL, "t6_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
